// File: rtl/motors_pkg.sv
// Shared definitions for the motor command executor: FSM states and timing defaults.
package Motors_PKG;

    // Clock cycles per step pulse (half high, half low).
    localparam int PULSE_PERIOD_CYCLES_DEFAULT = 4;
    // Cycles to wait after moving the pen servo before stepping starts.
    localparam int SERVO_SETTLE_CYCLES_DEFAULT = 10;

    // Executor FSM states.
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SERVO_WAIT = 2'd1,
        ST_STEP       = 2'd2,
        ST_DONE       = 2'd3
    } motors_state_t;

    // Bits needed for a counter running 0..max_value-1 (at least one bit).
    function automatic int counter_width(input int max_value);
        return (max_value > 2) ? $clog2(max_value) : 1;
    endfunction

endpackage

// File: rtl/servo_pkg.sv
// Servo position type shared by the pen-lift servo driver and its users.
package Servo_PKG;

    // Pen position as commanded to the servo.
    typedef enum logic {
        SERVO_POS_UP   = 1'b0,
        SERVO_POS_DOWN = 1'b1
    } servo_pos_t;

endpackage

// File: rtl/motors_ctrl_if.sv
// Command interface between the motion planner (master) and the executor (slave).
interface MotorsCtrl_IF #(
    parameter int PULSE_NUM_X_BITS = 16,
    parameter int PULSE_NUM_Y_BITS = 16
);
    import Servo_PKG::*;

    logic signed [PULSE_NUM_X_BITS-1:0] pulse_num_x;
    logic signed [PULSE_NUM_Y_BITS-1:0] pulse_num_y;
    servo_pos_t                         servo_pos;
    logic                               trigger;
    logic                               done;
    logic                               rdy;

    modport master (
        output pulse_num_x, pulse_num_y, servo_pos, trigger,
        input  done, rdy
    );

    modport slave (
        input  pulse_num_x, pulse_num_y, servo_pos, trigger,
        output done, rdy
    );

endinterface

// File: rtl/stepper_pulse_gen.sv
// One stepper axis: emits `count` pulses of PERIOD_CYCLES each after a start strobe.
// The first pulse is high in the cycle right after start; `last` flags the final
// cycle of the final period so the caller can move on without a dead cycle.
module stepper_pulse_gen
    import Motors_PKG::*;
#(
    parameter int COUNT_BITS    = 16,
    parameter int PERIOD_CYCLES = PULSE_PERIOD_CYCLES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [COUNT_BITS-1:0] count,
    output logic                  busy,
    output logic                  step,
    output logic                  last
);

    localparam int PHASE_BITS = counter_width(PERIOD_CYCLES);
    localparam logic [PHASE_BITS-1:0] PHASE_HALF_END = PHASE_BITS'(PERIOD_CYCLES / 2 - 1);
    localparam logic [PHASE_BITS-1:0] PHASE_LAST     = PHASE_BITS'(PERIOD_CYCLES - 1);
    localparam logic [COUNT_BITS-1:0] COUNT_ONE      = COUNT_BITS'(1);

    logic                  busy_q, busy_d;
    logic                  step_q, step_d;
    logic [PHASE_BITS-1:0] phase_q, phase_d;
    logic [COUNT_BITS-1:0] remaining_q, remaining_d;

    // Next-state logic: load on start, otherwise walk the phase within each period.
    always_comb begin
        busy_d      = busy_q;
        step_d      = step_q;
        phase_d     = phase_q;
        remaining_d = remaining_q;
        if (start) begin
            phase_d     = '0;
            remaining_d = count;
            busy_d      = (count != '0);
            step_d      = (count != '0);
        end else if (busy_q) begin
            if (phase_q == PHASE_LAST) begin
                phase_d = '0;
                if (remaining_q == COUNT_ONE) begin
                    busy_d      = 1'b0;
                    step_d      = 1'b0;
                    remaining_d = '0;
                end else begin
                    remaining_d = remaining_q - COUNT_ONE;
                    step_d      = 1'b1;
                end
            end else begin
                phase_d = phase_q + PHASE_BITS'(1);
                if (phase_q == PHASE_HALF_END) begin
                    step_d = 1'b0;
                end
            end
        end
    end

    // State registers; reset drops any pulse in flight immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q      <= 1'b0;
            step_q      <= 1'b0;
            phase_q     <= '0;
            remaining_q <= '0;
        end else begin
            busy_q      <= busy_d;
            step_q      <= step_d;
            phase_q     <= phase_d;
            remaining_q <= remaining_d;
        end
    end

    assign busy = busy_q;
    assign step = step_q;
    assign last = busy_q && (phase_q == PHASE_LAST) && (remaining_q == COUNT_ONE);

endmodule

// File: rtl/motors_ctrl_executor.sv
// Executes one plotter command: optional pen servo move with settle time, then
// concurrent X/Y step pulse trains, then a one-cycle done pulse.
`ifndef STEPPER_PULSE_NUM_X_BITS
`define STEPPER_PULSE_NUM_X_BITS 16
`endif
`ifndef STEPPER_PULSE_NUM_Y_BITS
`define STEPPER_PULSE_NUM_Y_BITS 16
`endif

module motors_ctrl_executor
    import Motors_PKG::*;
    import Servo_PKG::*;
#(
    parameter int PULSE_NUM_X_BITS    = `STEPPER_PULSE_NUM_X_BITS,
    parameter int PULSE_NUM_Y_BITS    = `STEPPER_PULSE_NUM_Y_BITS,
    parameter int PULSE_PERIOD_CYCLES = PULSE_PERIOD_CYCLES_DEFAULT,
    parameter int SERVO_SETTLE_CYCLES = SERVO_SETTLE_CYCLES_DEFAULT
) (
    input  logic         clk,
    input  logic         reset_n,
    MotorsCtrl_IF.slave  motors_intf_in,
    output logic         step_x,
    output logic         dir_x,
    output logic         step_y,
    output logic         dir_y,
    output servo_pos_t   servo_out,
    output logic         rdy,
    output logic         done
);

    localparam int WAIT_BITS = counter_width(SERVO_SETTLE_CYCLES);
    localparam logic [WAIT_BITS-1:0] WAIT_LAST = WAIT_BITS'(SERVO_SETTLE_CYCLES - 1);

    // Raw command fields; the sign bit gives direction, magnitude feeds the axes.
    logic [PULSE_NUM_X_BITS-1:0] raw_x;
    logic [PULSE_NUM_Y_BITS-1:0] raw_y;
    logic [PULSE_NUM_X_BITS-1:0] mag_x_in;
    logic [PULSE_NUM_Y_BITS-1:0] mag_y_in;
    servo_pos_t                  servo_pos_in;
    logic                        trigger_in;

    assign raw_x        = motors_intf_in.pulse_num_x;
    assign raw_y        = motors_intf_in.pulse_num_y;
    assign servo_pos_in = motors_intf_in.servo_pos;
    assign trigger_in   = motors_intf_in.trigger;

    // Unsigned negation keeps the most-negative value as 2^(BITS-1).
    assign mag_x_in = raw_x[PULSE_NUM_X_BITS-1] ? ((~raw_x) + PULSE_NUM_X_BITS'(1)) : raw_x;
    assign mag_y_in = raw_y[PULSE_NUM_Y_BITS-1] ? ((~raw_y) + PULSE_NUM_Y_BITS'(1)) : raw_y;

    motors_state_t               state_q, state_d;
    logic [WAIT_BITS-1:0]        wait_cnt_q, wait_cnt_d;
    servo_pos_t                  servo_q, servo_d;
    logic                        dir_x_q, dir_x_d;
    logic                        dir_y_q, dir_y_d;
    logic [PULSE_NUM_X_BITS-1:0] mag_x_q, mag_x_d;
    logic [PULSE_NUM_Y_BITS-1:0] mag_y_q, mag_y_d;

    logic                        start_steps;
    logic [PULSE_NUM_X_BITS-1:0] count_x;
    logic [PULSE_NUM_Y_BITS-1:0] count_y;
    logic                        busy_x, last_x, step_x_gen;
    logic                        busy_y, last_y, step_y_gen;
    logic                        axes_finishing;

    // Starting straight from IDLE uses the live magnitude; after a settle wait
    // the latched copy is used so later input changes cannot leak in.
    assign count_x = (state_q == ST_IDLE) ? mag_x_in : mag_x_q;
    assign count_y = (state_q == ST_IDLE) ? mag_y_in : mag_y_q;

    // An axis is finishing when idle or in the final cycle of its last pulse.
    assign axes_finishing = (!busy_x || last_x) && (!busy_y || last_y);

    // FSM next-state: accept in IDLE only, settle after servo moves, step, report.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        servo_d     = servo_q;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        mag_x_d     = mag_x_q;
        mag_y_d     = mag_y_q;
        start_steps = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trigger_in) begin
                    dir_x_d    = ~raw_x[PULSE_NUM_X_BITS-1];
                    dir_y_d    = ~raw_y[PULSE_NUM_Y_BITS-1];
                    mag_x_d    = mag_x_in;
                    mag_y_d    = mag_y_in;
                    servo_d    = servo_pos_in;
                    wait_cnt_d = '0;
                    if (servo_pos_in != servo_q) begin
                        state_d = ST_SERVO_WAIT;
                    end else begin
                        state_d     = ST_STEP;
                        start_steps = 1'b1;
                    end
                end
            end
            ST_SERVO_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d     = ST_STEP;
                    start_steps = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_BITS'(1);
                end
            end
            ST_STEP: begin
                if (axes_finishing) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Command and FSM registers with asynchronous abort.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            servo_q    <= SERVO_POS_UP;
            dir_x_q    <= 1'b0;
            dir_y_q    <= 1'b0;
            mag_x_q    <= '0;
            mag_y_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            servo_q    <= servo_d;
            dir_x_q    <= dir_x_d;
            dir_y_q    <= dir_y_d;
            mag_x_q    <= mag_x_d;
            mag_y_q    <= mag_y_d;
        end
    end

    stepper_pulse_gen #(
        .COUNT_BITS    (PULSE_NUM_X_BITS),
        .PERIOD_CYCLES (PULSE_PERIOD_CYCLES)
    ) u_gen_x (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start_steps),
        .count   (count_x),
        .busy    (busy_x),
        .step    (step_x_gen),
        .last    (last_x)
    );

    stepper_pulse_gen #(
        .COUNT_BITS    (PULSE_NUM_Y_BITS),
        .PERIOD_CYCLES (PULSE_PERIOD_CYCLES)
    ) u_gen_y (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start_steps),
        .count   (count_y),
        .busy    (busy_y),
        .step    (step_y_gen),
        .last    (last_y)
    );

    assign step_x    = step_x_gen;
    assign step_y    = step_y_gen;
    assign dir_x     = dir_x_q;
    assign dir_y     = dir_y_q;
    assign servo_out = servo_q;
    assign rdy       = (state_q == ST_IDLE);
    assign done      = (state_q == ST_DONE);

    assign motors_intf_in.rdy  = rdy;
    assign motors_intf_in.done = done;

endmodule
